// File: rtl/i2c_mon_pkg.sv
// Shared types for the passive I2C bus monitor: event kinds, the event
// record stored in the FIFO, the decoder state encoding and a helper.
package i2c_mon_pkg;

  // Width of the index field in a stored event; the top trims it to the
  // width its MAX_BYTES needs.
  localparam int IDX_MAX_W = 16;

  // Upper five bits of a 10-bit addressing first byte.
  localparam logic [4:0] TEN_BIT_PREFIX = 5'b11110;

  typedef enum logic [2:0] {
    EVT_START  = 3'd0,
    EVT_RSTART = 3'd1,
    EVT_ADDR   = 3'd2,
    EVT_ADDR2  = 3'd3,
    EVT_DATA   = 3'd4,
    EVT_STOP   = 3'd5,
    EVT_ERR    = 3'd6
  } evt_kind_e;

  typedef struct packed {
    evt_kind_e            kind;
    logic [7:0]           data;
    logic                 ack;
    logic [IDX_MAX_W-1:0] idx;
  } i2c_evt_s;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_ADDR2     = 3'd3,
    ST_ADDR2_ACK = 3'd4,
    ST_DATA      = 3'd5,
    ST_DATA_ACK  = 3'd6
  } mon_state_e;

  function automatic i2c_evt_s mk_evt(input evt_kind_e k, input logic [7:0] d,
                                      input logic a, input logic [IDX_MAX_W-1:0] i);
    i2c_evt_s e;
    e.kind = k;
    e.data = d;
    e.ack  = a;
    e.idx  = i;
    return e;
  endfunction

endpackage

// File: rtl/i2c_mon_evt_fifo.sv
// Synchronous event FIFO with a valid/ready read side. A push while full is
// accepted only if the head is popped in the same cycle; the caller detects
// drops from the full flag.
module i2c_mon_evt_fifo
  import i2c_mon_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  i2c_evt_s push_evt,
  input  logic     pop_ready,
  output logic     head_valid,
  output i2c_evt_s head_evt,
  output logic     full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  i2c_evt_s      mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          wr_en;

  assign head_valid = (count != '0);
  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign pop        = head_valid && pop_ready;
  assign wr_en      = push && (!full || pop);
  assign head_evt   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Event storage; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_evt;
  end

endmodule

// File: rtl/i2c_bus_monitor_rtl.sv
// Passive I2C bus monitor: conditions SCL/SDA, decodes START/RSTART/STOP,
// address and data bytes with their ACK bit, and queues events in a FIFO.
module i2c_bus_monitor_rtl
  import i2c_mon_pkg::*;
#(
  parameter int FILTER_LEN = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int TEN_BIT_EN = 1,
  parameter int MAX_BYTES  = 255,
  localparam int IDX_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             pclk,
  input  logic             areset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_kind,
  output logic [7:0]       evt_data,
  output logic             evt_ack,
  output logic [IDX_W-1:0] evt_idx,
  output logic             bus_busy,
  output logic             overflow,
  input  logic             overflow_clr
);

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(MAX_BYTES)) ? v : v + 1'b1;
  endfunction

  function automatic logic is_ten_bit_prefix(input logic [7:0] b);
    return (TEN_BIT_EN != 0) && (b[7:3] == TEN_BIT_PREFIX) && !b[0];
  endfunction

  // Line index 0 is SCL, 1 is SDA.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [1:0] filt_d;
  logic [3:0] stab_cnt [2];

  // Two-flop synchroniser, stability filter and one-cycle history per line.
  always_ff @(posedge pclk) begin
    if (areset) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      for (int i = 0; i < 2; i++) stab_cnt[i] <= '0;
    end else begin
      sync1  <= {sda_i, scl_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == 4'(FILTER_LEN - 1)) begin
          filt[i]     <= sync2[i];
          stab_cnt[i] <= '0;
        end else begin
          stab_cnt[i] <= stab_cnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_rise = filt[0] && !filt_d[0];
  assign scl_fall = !filt[0] && filt_d[0];
  assign start_c  = filt[0] && filt_d[0] && filt_d[1] && !filt[1];
  assign stop_c   = filt[0] && filt_d[0] && !filt_d[1] && filt[1];

  mon_state_e       state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [IDX_W-1:0] byte_idx, byte_idx_n;
  logic             busy, busy_n;
  logic             bit_smp, bit_smp_n;
  logic             bit_pend, bit_pend_n;
  logic             push_q, push_n;
  i2c_evt_s         push_evt_q, push_evt_n;
  logic             epend_q, epend_n;
  i2c_evt_s         epend_evt_q, epend_evt_n;
  i2c_evt_s         cond_evt;

  // Decoder state and registered event push.
  always_ff @(posedge pclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      bit_pend <= 1'b0;
      push_q   <= 1'b0;
      epend_q  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_idx <= byte_idx_n;
      busy     <= busy_n;
      bit_pend <= bit_pend_n;
      push_q   <= push_n;
      epend_q  <= epend_n;
    end
    shreg       <= shreg_n;
    bit_smp     <= bit_smp_n;
    push_evt_q  <= push_evt_n;
    epend_evt_q <= epend_evt_n;
  end

  // Next-state decode. Data bits are sampled on SCL rise but only committed on
  // SCL fall, so the SCL rise that precedes a STOP or repeated START is never
  // counted as a bit. The ACK bit is final at SCL rise and pushes its event there.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    byte_idx_n  = byte_idx;
    busy_n      = busy;
    bit_smp_n   = bit_smp;
    bit_pend_n  = bit_pend;
    push_n      = 1'b0;
    push_evt_n  = push_evt_q;
    epend_n     = 1'b0;
    epend_evt_n = epend_evt_q;
    cond_evt    = mk_evt(EVT_START, 8'h00, 1'b0, '0);

    // Second half of an ERR + condition pair.
    if (epend_q) begin
      push_n     = 1'b1;
      push_evt_n = epend_evt_q;
    end

    if (start_c) begin
      cond_evt   = mk_evt(busy ? EVT_RSTART : EVT_START, 8'h00, 1'b0, '0);
      bit_pend_n = 1'b0;
      bit_cnt_n  = '0;
      byte_idx_n = '0;
      busy_n     = 1'b1;
      state_n    = ST_ADDR;
      push_n     = 1'b1;
      if (busy && bit_cnt != '0) begin
        push_evt_n  = mk_evt(EVT_ERR, 8'h00, 1'b0, '0);
        epend_n     = 1'b1;
        epend_evt_n = cond_evt;
      end else begin
        push_evt_n = cond_evt;
      end
    end else if (stop_c) begin
      bit_pend_n = 1'b0;
      if (busy) begin
        cond_evt  = mk_evt(EVT_STOP, 8'h00, 1'b0, '0);
        bit_cnt_n = '0;
        busy_n    = 1'b0;
        state_n   = ST_IDLE;
        push_n    = 1'b1;
        if (bit_cnt != '0) begin
          push_evt_n  = mk_evt(EVT_ERR, 8'h00, 1'b0, '0);
          epend_n     = 1'b1;
          epend_evt_n = cond_evt;
        end else begin
          push_evt_n = cond_evt;
        end
      end
    end else if (scl_rise) begin
      case (state)
        ST_ADDR, ST_ADDR2, ST_DATA: begin
          bit_smp_n  = filt[1];
          bit_pend_n = 1'b1;
        end
        ST_ADDR_ACK: begin
          push_n     = 1'b1;
          push_evt_n = mk_evt(EVT_ADDR, shreg, !filt[1], '0);
          bit_cnt_n  = '0;
          state_n    = is_ten_bit_prefix(shreg) ? ST_ADDR2 : ST_DATA;
        end
        ST_ADDR2_ACK: begin
          push_n     = 1'b1;
          push_evt_n = mk_evt(EVT_ADDR2, shreg, !filt[1], '0);
          bit_cnt_n  = '0;
          state_n    = ST_DATA;
        end
        ST_DATA_ACK: begin
          push_n     = 1'b1;
          push_evt_n = mk_evt(EVT_DATA, shreg, !filt[1], IDX_MAX_W'(byte_idx));
          byte_idx_n = sat_inc(byte_idx);
          bit_cnt_n  = '0;
          state_n    = ST_DATA;
        end
        default: ;
      endcase
    end else if (scl_fall && bit_pend) begin
      shreg_n    = {shreg[6:0], bit_smp};
      bit_pend_n = 1'b0;
      bit_cnt_n  = bit_cnt + 4'd1;
      if (bit_cnt == 4'd7) begin
        case (state)
          ST_ADDR:  state_n = ST_ADDR_ACK;
          ST_ADDR2: state_n = ST_ADDR2_ACK;
          ST_DATA:  state_n = ST_DATA_ACK;
          default:  ;
        endcase
      end
    end
  end

  i2c_evt_s head_evt;
  logic     head_valid;
  logic     fifo_full;

  i2c_mon_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (pclk),
    .rst        (areset),
    .push       (push_q),
    .push_evt   (push_evt_q),
    .pop_ready  (evt_ready),
    .head_valid (head_valid),
    .head_evt   (head_evt),
    .full       (fifo_full)
  );

  // Sticky drop flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge pclk) begin
    if (areset) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full && !(head_valid && evt_ready)) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign evt_valid = head_valid;
  assign evt_kind  = head_valid ? head_evt.kind : 3'd0;
  assign evt_data  = head_valid ? head_evt.data : 8'h00;
  assign evt_ack   = head_valid ? head_evt.ack : 1'b0;
  assign evt_idx   = head_valid ? IDX_W'(head_evt.idx) : '0;
  assign bus_busy  = busy;

endmodule

// File: doc/i2c_bus_monitor_rtl.md
Name: i2c_bus_monitor_rtl

Overview:
- Synthesizable, passive I2C bus monitor: the parametrised successor to the slave monitor BFM.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Decodes 7-bit or 10-bit address bytes and data bytes with their ACK/NACK bit, and flags protocol errors.
- Buffers decoded events in a FIFO read through a valid/ready port by scoreboards or on-chip debug logic.

Parameters:
- FILTER_LEN, 3: cycles a synchronised line must be stable before the filtered value changes (1..15).
- FIFO_DEPTH, 8: event FIFO entries; power of 2, at least 2.
- TEN_BIT_EN, 1: 1 = decode a 11110xx first address byte as a 10-bit prefix; 0 = treat every address as 7-bit.
- MAX_BYTES, 255: saturation value of the per-transfer data byte index.

Ports:
- pclk  in  1  system clock, the single clock of the block.
- areset  in  1  reset, synchronous, active-high.
- scl_i  in  1  raw SCL pin, asynchronous to pclk.
- sda_i  in  1  raw SDA pin, asynchronous to pclk.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head event.
- evt_kind  out  3  0 START, 1 RSTART, 2 ADDR, 3 ADDR2, 4 DATA, 5 STOP, 6 ERR.
- evt_data  out  8  the byte; zero for START, RSTART, STOP and ERR events.
- evt_ack  out  1  1 = ACK (9th bit low), 0 = NACK.
- evt_idx  out  $clog2(MAX_BYTES+1)  data byte index since the last START/RSTART.
- bus_busy  out  1  1 from a START until a STOP.
- overflow  out  1  sticky; set when an event is dropped.
- overflow_clr  in  1  clears overflow.

Behaviour:
- Reset (areset high at a pclk edge):
  - FSM goes to IDLE; FIFO empties.
  - evt_valid=0, evt_kind=0, evt_data=0, evt_ack=0, evt_idx=0, bus_busy=0, overflow=0.
  - Synchronisers and filtered lines reset to 1 (idle bus).
  - Reset mid-transfer discards the partial byte; no STOP event is generated.
- Input conditioning:
  - Each line passes through a 2-flop synchroniser.
  - A per-line stability counter lets the filtered value follow the synchronised value only after FILTER_LEN equal consecutive samples.
  - Edge detection runs on the filtered lines only.
- Conditions:
  - START: SDA falling while SCL is high.
  - STOP: SDA rising while SCL is high.
  - Bit sample: SCL rising edge, sampling SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, ADDR2, ADDR2_ACK, DATA, DATA_ACK.
  - IDLE: ignores all bits until a START.
  - START in IDLE: push START, bus_busy=1, go to ADDR.
  - START while bus_busy: push RSTART, go to ADDR.
  - On every START/RSTART: bit counter=0, byte index=0.
  - ADDR, ADDR2, DATA: shift in 8 bits MSB first, then move to the matching *_ACK state.
  - *_ACK state: the 9th bit gives evt_ack; push the event.
  - After the ADDR event: if TEN_BIT_EN and the byte matches 11110xx0, go to ADDR2; otherwise go to DATA.
  - After the ADDR2 event: go to DATA.
  - After each DATA event: byte index increments, saturating at MAX_BYTES.
  - STOP: push STOP, bus_busy=0, go to IDLE.
  - START or STOP with bit counter in 1..8: push ERR, then the START/RSTART or STOP event, in consecutive cycles.
- Latency: an event is pushed the cycle after the filtered edge that completes it.
  - evt_valid rises the following cycle if the FIFO was empty.
  - Raw pin to evt_valid: 2 + FILTER_LEN + 2 cycles.
- FIFO rules:
  - Pop when evt_valid && evt_ready.
  - Push while full without a pop: drop the new event, set overflow.
  - Push and pop in the same cycle while full: both succeed.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow_clr in the same cycle as a new drop: overflow stays set (set wins).
  - Output fields are stable while evt_valid && !evt_ready.

Decomposition:
- Package i2c_mon_pkg:
  - evt_kind_e enum.
  - i2c_evt_s struct (kind, data, ack, idx).
  - TEN_BIT_PREFIX = 5'b11110.
  - FSM state enum.
- Sub-module i2c_mon_evt_fifo: parametrised synchronous FIFO of i2c_evt_s with valid/ready pop, full flag and drop-on-full.
- Conditioning, FSM and FIFO together fit the 120-400 line RTL budget.

Test Plan:
- Write to 7-bit address 0x50, bytes 0xA5, 0x3C, all ACKed, then STOP, with evt_ready=1 -> events in order: START; ADDR data=0xA0 ack=1; DATA 0xA5 idx=0; DATA 0x3C idx=1; STOP. bus_busy high only between START and STOP.
- 10-bit read, first byte 0xF2 then 0x34, then RSTART and 0xF3; master NACKs the last data byte 0x77 -> START, ADDR 0xF2, ADDR2 0x34, RSTART, ADDR 0xF3, DATA 0x77 ack=0, STOP. With TEN_BIT_EN=0 the 0x34 byte decodes as DATA idx=0.
- Glitch of FILTER_LEN-1 cycles on SDA while SCL is high -> no event. A glitch of FILTER_LEN cycles -> START.
- STOP after 4 data bits -> ERR then STOP, FSM back in IDLE.
- FIFO_DEPTH=8, evt_ready=0, a transaction producing 11 events -> first 8 retained, overflow=1. Draining returns exactly those 8. overflow_clr clears the flag.
- areset asserted mid-data-byte -> next cycle all outputs at reset values. Bits sent before the next START produce no events.
